// File: rtl/alu_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter_if
// Bundles every non-clock signal of alu_req_arbiter:
//   req0_* / req1_*   : request channels (valid/ready, a, b, opcode)
//   rsp0_* / rsp1_*   : response handshakes (valid/ready)
//   rsp_result/z/c/err: shared response payload, qualified by rspN_valid
//   alu_*             : operands/opcode to, and result/flags from, the ALU
// Modport slave is the arbiter side; modport master is the environment side
// (requesters plus the external ALU).
// ---------------------------------------------------------------------------
interface alu_req_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [2:0] req0_opcode;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [2:0] req1_opcode;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp_result;
  logic       rsp_z;
  logic       rsp_c;
  logic       rsp_err;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_flag_z;
  logic       alu_flag_c;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_opcode,
    input  req1_valid, req1_a, req1_b, req1_opcode,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    input  rsp0_ready, rsp1_ready,
    output rsp_result, rsp_z, rsp_c, rsp_err,
    output alu_a, alu_b, alu_opcode,
    input  alu_result, alu_flag_z, alu_flag_c
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_opcode,
    output req1_valid, req1_a, req1_b, req1_opcode,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    output rsp0_ready, rsp1_ready,
    input  rsp_result, rsp_z, rsp_c, rsp_err,
    input  alu_a, alu_b, alu_opcode,
    output alu_result, alu_flag_z, alu_flag_c
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
// Two-port round-robin request arbiter/sequencer for a shared 8-bit ALU.
// One request is in flight at a time: IDLE (accept) -> EXEC (ALU sees the
// registered operands, result captured at the end of the cycle) -> RESP
// (response held until the granted port takes it). Priority toggles to the
// other port only when a response completes.
//
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_req_arbiter_if.slave (request, response and ALU signals)
// Parameters:
//   RESET_PRIO : port holding priority after reset (0 or 1)
// Build option:
//   ALU_ARB_ERR_EN : when defined, opcodes 101-111 return rsp_err=1 with a
//                    zeroed result and flags; when undefined rsp_err is 0 and
//                    the ALU output is captured whatever the opcode.
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic       grant_q, grant_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [7:0] res_q, res_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic       err_q, err_d;

  logic       prio_valid_s;
  logic       other_valid_s;
  logic       sel_s;
  logic       accept_s;
  logic       rsp_fire_s;

  // Opcodes above eor (3'b100) have no ALU meaning.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op > 3'd4);
  endfunction

  // Candidate grant: the priority port if it asks, else the other port if it
  // asks; with nobody asking the priority port is offered ready.
  always_comb begin
    prio_valid_s  = prio_q ? bus.req1_valid : bus.req0_valid;
    other_valid_s = prio_q ? bus.req0_valid : bus.req1_valid;
    if (prio_valid_s || !other_valid_s) begin
      sel_s = prio_q;
    end else begin
      sel_s = ~prio_q;
    end
  end

  assign accept_s   = (state_q == ST_IDLE) && (sel_s ? bus.req1_valid : bus.req0_valid);
  assign rsp_fire_s = (state_q == ST_RESP) && (grant_q ? bus.rsp1_ready : bus.rsp0_ready);

  // Next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_EXEC;
          grant_d = sel_s;
          if (sel_s) begin
            a_d  = bus.req1_a;
            b_d  = bus.req1_b;
            op_d = bus.req1_opcode;
          end else begin
            a_d  = bus.req0_a;
            b_d  = bus.req0_b;
            op_d = bus.req0_opcode;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
`ifdef ALU_ARB_ERR_EN
        if (is_illegal_op(op_q)) begin
          res_d = 8'h00;
          z_d   = 1'b0;
          c_d   = 1'b0;
          err_d = 1'b1;
        end else begin
          res_d = bus.alu_result;
          z_d   = bus.alu_flag_z;
          c_d   = bus.alu_flag_c;
          err_d = 1'b0;
        end
`else
        res_d = bus.alu_result;
        z_d   = bus.alu_flag_z;
        c_d   = bus.alu_flag_c;
        err_d = 1'b0;
`endif
      end
      ST_RESP: begin
        if (rsp_fire_s) begin
          state_d = ST_IDLE;
          prio_d  = ~grant_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= RESET_PRIO;
      grant_q <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'b000;
      res_q   <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  // Ready is gated by rst_n so it is low for the whole reset assertion,
  // not just after the first clock.
  assign bus.req0_ready = rst_n && (state_q == ST_IDLE) && !sel_s;
  assign bus.req1_ready = rst_n && (state_q == ST_IDLE) && sel_s;

  assign bus.rsp0_valid = (state_q == ST_RESP) && !grant_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) && grant_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_c      = c_q;
  assign bus.rsp_err    = err_q;

  // ALU inputs always follow the operand registers.
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_opcode = op_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter, including a behavioural ALU.
module tb_alu_req_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef ALU_ARB_ERR_EN
  localparam int OP_MAX = 7;
`else
  localparam int OP_MAX = 4;
`endif

  alu_req_arbiter_if bus();

  alu_req_arbiter #(.RESET_PRIO(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External ALU: add/sub/and/or/eor, C = carry on add, no-borrow on sub.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum        = 9'd0;
    bus.alu_flag_c = 1'b0;
    case (bus.alu_opcode)
      3'd0: begin
        alu_sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = alu_sum[7:0];
        bus.alu_flag_c = alu_sum[8];
      end
      3'd1: begin
        bus.alu_result = bus.alu_a - bus.alu_b;
        bus.alu_flag_c = (bus.alu_a >= bus.alu_b);
      end
      3'd2: bus.alu_result = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_result = bus.alu_a | bus.alu_b;
      3'd4: bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: begin
        bus.alu_result = 8'hA5;
        bus.alu_flag_c = 1'b1;
      end
    endcase
    bus.alu_flag_z = (bus.alu_opcode <= 3'd4) && (bus.alu_result == 8'h00);
  end

  // Expected response {err, z, c, result} from plain integer arithmetic.
  function automatic logic [10:0] ref_rsp(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    int r;
    bit c;
    r = 0;
    c = 1'b0;
    case (op)
      3'd0: begin r = int'(a) + int'(b); c = (r > 255); r = r % 256; end
      3'd1: begin r = (int'(a) - int'(b) + 256) % 256; c = (int'(a) >= int'(b)); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      default: return {1'b1, 1'b0, 1'b0, 8'h00};
    endcase
    return {1'b0, (r == 0), c, 8'(r)};
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'h00; bus.req0_opcode = 3'd0;
    bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00; bus.req1_opcode = 3'd0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one request and wait (bounded) for it to be accepted; returns at
  // the accept edge + 1, i.e. inside the EXEC cycle.
  task automatic send(input bit port, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (port) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_opcode = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_opcode = op;
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      if (port ? bus.req1_ready : bus.req0_ready) begin
        @(posedge clk);
        ok = 1'b1;
        #1;
        break;
      end
      @(negedge clk);
    end
    if (port) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_handshake got %b want 0000",
                         {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
    end
    checks++;
    if ({bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== 11'd0) begin
      errors++; $display("FAIL reset_rsp got %h want 000",
                         {bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result});
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== 19'd0) begin
      errors++; $display("FAIL reset_alu got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_opcode});
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_port0_add();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 8'h05; bus.req0_b = 8'h03; bus.req0_opcode = 3'b000;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL p0_accept_ready got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready} !== 4'b0000) begin
      errors++; $display("FAIL p0_exec_idle got %b want 0000",
                         {bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== {8'h05, 8'h03, 3'b000}) begin
      errors++; $display("FAIL p0_alu_drive got %h want %h",
                         {bus.alu_a, bus.alu_b, bus.alu_opcode}, {8'h05, 8'h03, 3'b000});
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10) begin
      errors++; $display("FAIL p0_rsp_valid got %b want 10", {bus.rsp0_valid, bus.rsp1_valid});
    end
    checks++;
    if ({bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== {3'b000, 8'h08}) begin
      errors++; $display("FAIL p0_rsp_data got %h want 008",
                         {bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result});
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
      errors++; $display("FAIL p0_rsp_done got %b want 00", {bus.rsp0_valid, bus.rsp1_valid});
    end
  endtask

  task automatic test_port1_sub();
    bit ok;
    send(1'b1, 8'h10, 8'h10, 3'b001, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL p1_accept got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp0_valid !== 1'b0) begin
        errors++; $display("FAIL p1_no_rsp0 cycle %0d got %b want 0", i, bus.rsp0_valid);
      end
      if (i == 1) begin
        checks++;
        if ({bus.rsp1_valid, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== {3'b111, 8'h00}) begin
          errors++; $display("FAIL p1_rsp got %h want 700",
                             {bus.rsp1_valid, bus.rsp_z, bus.rsp_c, bus.rsp_result});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit          acc_port[$];
    int          acc_cyc[$];
    bit          pend_port[$];
    logic [10:0] pend_exp[$];
    bit          a0, a1, p;
    logic [10:0] e;
    int          cyc, n_done;
    apply_reset();
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
    bus.req0_opcode = 3'($urandom_range(0, 4));
    bus.req1_valid = 1'b1; bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
    bus.req1_opcode = 3'($urandom_range(0, 4));
    cyc = 0;
    n_done = 0;
    while (n_done < 4 && cyc < 60) begin
      #1;
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      if (a0 || a1) begin
        acc_port.push_back(a1);
        acc_cyc.push_back(cyc);
        pend_port.push_back(a1);
        pend_exp.push_back(a1 ? ref_rsp(bus.req1_a, bus.req1_b, bus.req1_opcode)
                              : ref_rsp(bus.req0_a, bus.req0_b, bus.req0_opcode));
      end
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        checks++;
        if (pend_port.size() == 0) begin
          errors++; $display("FAIL rr_rsp_unexpected got %b want none", {bus.rsp0_valid, bus.rsp1_valid});
        end else begin
          p = pend_port.pop_front();
          e = pend_exp.pop_front();
          if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_z, bus.rsp_c, bus.rsp_result}
              !== {~p, p, e[9:0]}) begin
            errors++; $display("FAIL rr_rsp got %h want %h",
                               {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_z, bus.rsp_c, bus.rsp_result},
                               {~p, p, e[9:0]});
          end
          n_done++;
        end
      end
      @(posedge clk); #1;
      if (acc_port.size() >= 4) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else begin
        if (a0) begin
          bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom); bus.req0_opcode = 3'($urandom_range(0, 4));
        end
        if (a1) begin
          bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom); bus.req1_opcode = 3'($urandom_range(0, 4));
        end
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    checks++;
    if (n_done != 4 || acc_port.size() != 4) begin
      errors++; $display("FAIL rr_count got %0d/%0d want 4/4", acc_port.size(), n_done);
    end
    for (int i = 0; i < acc_port.size(); i++) begin
      checks++;
      if (acc_port[i] != 1'(i % 2)) begin
        errors++; $display("FAIL rr_order idx %0d got %0d want %0d", i, acc_port[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
          errors++; $display("FAIL rr_interval idx %0d got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    apply_reset();
    send(1'b0, 8'hFF, 8'h01, 3'b000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_accept got 0 want 1"); end
    bus.req1_valid = 1'b1; bus.req1_a = 8'hF0; bus.req1_b = 8'h3C; bus.req1_opcode = 3'b010;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== {4'b1011, 8'h00}) begin
        errors++; $display("FAIL stall_hold cycle %0d got %h want b00", i,
                           {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_z, bus.rsp_c, bus.rsp_result});
      end
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        errors++; $display("FAIL stall_ready cycle %0d got %b want 00", i, {bus.req0_ready, bus.req1_ready});
      end
    end
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({bus.rsp0_valid, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
      errors++; $display("FAIL stall_release got %b want 001", {bus.rsp0_valid, bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rsp1_valid, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== {4'b1000, 8'h30}) begin
      errors++; $display("FAIL stall_next_rsp got %h want 830",
                         {bus.rsp1_valid, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_exec();
    bit ok;
    send(1'b0, 8'h22, 8'h11, 3'b001, ok);
    repeat (3) @(negedge clk);
    send(1'b1, 8'h01, 8'h02, 3'b000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstx_accept got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready, bus.rsp_result, bus.alu_a}
        !== 20'd0) begin
      errors++; $display("FAIL rstx_clear got %h want 0",
                         {bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready, bus.rsp_result, bus.alu_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
        errors++; $display("FAIL rstx_dropped cycle %0d got %b want 00", i, {bus.rsp0_valid, bus.rsp1_valid});
      end
    end
    bus.req0_valid = 1'b1; bus.req0_a = 8'h0F; bus.req0_b = 8'h01; bus.req0_opcode = 3'b011;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h77; bus.req1_b = 8'h01; bus.req1_opcode = 3'b000;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rstx_prio got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.rsp0_valid, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== {4'b1000, 8'h0F}) begin
      errors++; $display("FAIL rstx_next got %h want 80f",
                         {bus.rsp0_valid, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result});
    end
    @(negedge clk);
  endtask

  // Random traffic against a transaction-level model: idle / executing /
  // responding, one request outstanding, priority flips on completion.
  task automatic test_random();
    int          phase;
    bit          m_prio, m_grant, g, clr0, clr1;
    logic [10:0] m_exp;
    logic [18:0] m_alu;
    logic [1:0]  exp2;
    int          n_done;
    apply_reset();
    phase = 0; m_prio = 1'b0; m_grant = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    m_exp = 11'd0; m_alu = 19'd0; n_done = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (clr0) bus.req0_valid = 1'b0;
      if (clr1) bus.req1_valid = 1'b0;
      if (!bus.req0_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.req0_valid = 1'b1; bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
          bus.req0_opcode = 3'($urandom_range(0, OP_MAX));
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.req0_valid = 1'b0;
      end
      if (!bus.req1_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.req1_valid = 1'b1; bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
          bus.req1_opcode = 3'($urandom_range(0, OP_MAX));
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.req1_valid = 1'b0;
      end
      bus.rsp0_ready = ($urandom_range(0, 2) != 0);
      bus.rsp1_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (m_prio) g = bus.req1_valid ? 1'b1 : !bus.req0_valid;
      else        g = bus.req0_valid ? 1'b0 : bus.req1_valid;
      if (phase != 0 || bus.req0_valid || bus.req1_valid) begin
        exp2 = (phase == 0) ? (g ? 2'b01 : 2'b10) : 2'b00;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== exp2) begin
          errors++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, {bus.req0_ready, bus.req1_ready}, exp2);
        end
      end
      exp2 = (phase == 2) ? (m_grant ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== exp2) begin
        errors++; $display("FAIL rand_rsp_valid cyc %0d got %b want %b", cyc, {bus.rsp0_valid, bus.rsp1_valid}, exp2);
      end
      if (phase == 2) begin
        checks++;
        if ({bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== m_exp) begin
          errors++; $display("FAIL rand_rsp_data cyc %0d got %h want %h", cyc,
                             {bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result}, m_exp);
        end
      end
      if (phase == 1) begin
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== m_alu) begin
          errors++; $display("FAIL rand_alu cyc %0d got %h want %h", cyc,
                             {bus.alu_a, bus.alu_b, bus.alu_opcode}, m_alu);
        end
      end
      clr0 = 1'b0;
      clr1 = 1'b0;
      case (phase)
        0: begin
          if (g ? bus.req1_valid : bus.req0_valid) begin
            m_grant = g;
            m_alu = g ? {bus.req1_a, bus.req1_b, bus.req1_opcode} : {bus.req0_a, bus.req0_b, bus.req0_opcode};
            m_exp = ref_rsp(m_alu[18:11], m_alu[10:3], m_alu[2:0]);
            phase = 1;
            if (g) clr1 = 1'b1;
            else   clr0 = 1'b1;
          end
        end
        1: phase = 2;
        2: begin
          if (m_grant ? bus.rsp1_ready : bus.rsp0_ready) begin
            phase = 0;
            m_prio = ~m_grant;
            n_done++;
          end
        end
        default: phase = 0;
      endcase
      @(posedge clk);
    end
    idle_inputs();
    checks++;
    if (n_done < 30) begin
      errors++; $display("FAIL rand_progress got %0d want >=30", n_done);
    end
  endtask

`ifdef ALU_ARB_ERR_EN
  task automatic test_err();
    bit ok;
    apply_reset();
    bus.rsp0_ready = 1'b1;
    send(1'b0, 8'hAA, 8'h55, 3'b111, ok);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ok, bus.rsp0_valid, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== {5'b11100, 8'h00}) begin
      errors++; $display("FAIL err_illegal got %h want 1c00",
                         {ok, bus.rsp0_valid, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result});
    end
    @(negedge clk);
    send(1'b0, 8'hF0, 8'h3C, 3'b010, ok);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ok, bus.rsp0_valid, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result} !== {5'b11000, 8'h30}) begin
      errors++; $display("FAIL err_legal got %h want 1830",
                         {ok, bus.rsp0_valid, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_result});
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_port0_add();
    test_port1_sub();
    test_back_to_back();
    test_stall();
    test_reset_in_exec();
    test_random();
`ifdef ALU_ARB_ERR_EN
    test_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-port request arbiter and sequencer for the shared 8-bit ALU. Accepts operand/opcode requests from two independent requesters over valid/ready handshakes, grants one at a time round-robin, drives the ALU from registered operands, captures result and Z/C flags, and returns them on the granted port's response channel with backpressure. Sits between the datapath requesters (e.g. execute unit and address-calc unit) and a single externally instantiated `alu_8bit`.

## Interface
- `RESET_PRIO`, default 0: requester that holds priority after reset (0 or 1).
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request present on port 0 / 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when `valid` and `ready` are both high.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  8  operands.
- `req0_opcode` / `req1_opcode`  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 eor.
- `rsp0_valid` / `rsp1_valid`  out  1  response present for port 0 / 1.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes response.
- `rsp_result`  out  8  captured ALU result; shared by both ports, qualified by `rspN_valid`.
- `rsp_z`, `rsp_c`  out  1  captured Z and C flags.
- `rsp_err`  out  1  illegal opcode; only meaningful with `ALU_ARB_ERR_EN`.
- `alu_a`, `alu_b`  out  8  operands to ALU.
- `alu_opcode`  out  3  opcode to ALU.
- `alu_result`  in  8  ALU result.
- `alu_flag_z`, `alu_flag_c`  in  1  ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Grant is the priority port if it is valid, otherwise the other port if it is valid.
  - `reqN_ready` = (state==IDLE) & (grant==N). It is combinational on `reqX_valid`.
  - On handshake: latch a, b, opcode and grant ID, then go to EXEC.
- **EXEC:**
  - `alu_*` are driven from the operand registers.
  - At the clock edge, capture `alu_result`, `alu_flag_z` and `alu_flag_c` into the response registers, then go to RESP.
- **RESP:**
  - `rsp<grant>_valid` = 1, the other port's `rsp_valid` = 0.
  - Response registers hold stable until `rsp<grant>_ready` = 1.
  - On handshake: go to IDLE and set priority to the other port.
- Round-robin: priority toggles only on response completion, never on acceptance alone. With both ports valid continuously, grants alternate 0,1,0,1 starting at `RESET_PRIO`.
- `alu_a`, `alu_b` and `alu_opcode` always reflect the operand registers, which hold their last value outside EXEC.
- C flag is passed through unmodified; the ALU already zeroes C for logic ops.
- Reset values: state IDLE; priority `RESET_PRIO`; operand, opcode and response registers 0; all `rsp*_valid` and `req*_ready` 0 during reset; `rsp_err` 0.

## Timing
- Accept at edge T.
- EXEC during cycle T+1.
- `rspN_valid` high from T+2.
- Minimum accept-to-response latency is 2 cycles.
- Minimum issue interval is 3 cycles; no request is accepted while in EXEC or RESP.
- A response handshake at edge T+2 returns the FSM to IDLE. The next accept can occur at edge T+3.
- No bypass: requests are never accepted in the same cycle as a response handshake.
- `rsp_ready` held low stalls the block indefinitely in RESP. Both `req*_ready` stay low during the stall.
- Asserting `rst_n` low in any state immediately clears state and outputs to reset values. Any in-flight request is dropped with no response.
- A requester deasserting `valid` without a handshake is legal; nothing is latched.

## Configuration
- Macro: `ALU_ARB_ERR_EN`.
- **Defined:**
  - An opcode of 101–111 latched at accept sets `rsp_err` = 1 at capture.
  - `rsp_result` is forced to 8'h00 and `rsp_z`/`rsp_c` are forced to 0. ALU outputs are ignored.
  - Timing is unchanged: the request still passes through EXEC.
  - `rsp_err` = 0 for legal opcodes.
- **Undefined:**
  - `rsp_err` is tied to 0.
  - Illegal opcodes pass to the ALU unchanged, and whatever the ALU returns is captured. The response is undefined.

## Test plan
- Reset, then port 0 only: 8'h05 + 8'h03, opcode 000 -> `req0_ready` high in the accept cycle; `rsp0_valid` 2 cycles later; `rsp_result` 8'h08, `rsp_z` 0, `rsp_c` 0; `rsp1_valid` stays 0.
- Port 1 only: sub 8'h10 - 8'h10 -> `rsp_result` 8'h00, `rsp_z` 1, `rsp_c` 1; `rsp0_valid` never asserts.
- Both ports valid for 4 ops, `rsp_ready` tied high, `RESET_PRIO`=0 -> grant order 0,1,0,1; each issue interval is exactly 3 cycles.
- Response stall: `rsp0_ready` held low 5 cycles after add 8'hFF + 8'h01 -> `rsp_result` 8'h00, `rsp_z` 1, `rsp_c` 1 held stable all 5 cycles; both `req_ready` low; no further accepts.
- `rst_n` pulsed low while in EXEC -> all `rsp_valid` 0, state IDLE, priority `RESET_PRIO`; the next request completes normally.
- With `ALU_ARB_ERR_EN`: opcode 111, a=8'hAA, b=8'h55 -> `rsp_err` 1, `rsp_result` 8'h00, `rsp_z` 0, `rsp_c` 0, with 2-cycle latency; the following legal and 8'hF0 & 8'h3C gives 8'h30 with `rsp_err` 0.
